// File: rtl/cdot_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cdot_pkg
// Description : Shared types and helpers for the complex dot-product controller.
// Revision    : 1.0 - initial release
// ============================================================================
package cdot_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic {
        SUM = 1'b0,
        SUB = 1'b1
    } op_e;

    function automatic int acc_width(input int width, input int max_len);
        return 2 * width + $clog2(max_len) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cdot_accum.sv
`default_nettype none
// ============================================================================
// Module      : cdot_accum
// Description : Product pipe register plus two sign-extending accumulators.
// Revision    : 1.0 - initial release
// ============================================================================
module cdot_accum #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 21
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clr,
    input  logic               i_load,
    input  logic [2*WIDTH:0]   i_p_re,
    input  logic [2*WIDTH:0]   i_p_im,
    output logic [ACC_W-1:0]   o_acc_re,
    output logic [ACC_W-1:0]   o_acc_im,
    output logic               o_pv
);

    localparam int PW = 2 * WIDTH + 1;

    logic [PW-1:0]    r_pr_re;
    logic [PW-1:0]    r_pr_im;
    logic             r_pv;
    logic [ACC_W-1:0] r_acc_re;
    logic [ACC_W-1:0] r_acc_im;
    logic [ACC_W-1:0] w_ext_re;
    logic [ACC_W-1:0] w_ext_im;

    assign w_ext_re = {{(ACC_W-PW){r_pr_re[PW-1]}}, r_pr_re};
    assign w_ext_im = {{(ACC_W-PW){r_pr_im[PW-1]}}, r_pr_im};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pr_re  <= '0;
            r_pr_im  <= '0;
            r_pv     <= 1'b0;
            r_acc_re <= '0;
            r_acc_im <= '0;
        end else begin
            r_pv <= i_load;
            if (i_load) begin
                r_pr_re <= i_p_re;
                r_pr_im <= i_p_im;
            end
            if (i_clr) begin
                r_acc_re <= '0;
                r_acc_im <= '0;
            end else if (r_pv) begin
                r_acc_re <= r_acc_re + w_ext_re;
                r_acc_im <= r_acc_im + w_ext_im;
            end
        end
    end

    assign o_acc_re = r_acc_re;
    assign o_acc_im = r_acc_im;
    assign o_pv     = r_pv;

endmodule
`default_nettype wire

// File: rtl/complexMul.sv
`default_nettype none
// ============================================================================
// Module      : complexMul
// Description : Combinational complex multiplier, p = a * b.
// Revision    : 1.0 - initial release
// ============================================================================
module complexMul
    import cdot_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]   i_a_re,
    input  logic [WIDTH-1:0]   i_a_im,
    input  logic [WIDTH-1:0]   i_b_re,
    input  logic [WIDTH-1:0]   i_b_im,
    output logic [2*WIDTH:0]   o_p_re,
    output logic [2*WIDTH:0]   o_p_im
);

    // One extra result bit: (-2^(W-1))^2 summed twice reaches +2^(2W-1).
    localparam int PW = 2 * WIDTH + 1;

    logic signed [2*WIDTH-1:0] w_rr;
    logic signed [2*WIDTH-1:0] w_ii;
    logic signed [2*WIDTH-1:0] w_ir;
    logic signed [2*WIDTH-1:0] w_ri;

    function automatic logic [PW-1:0] addsub(
        input op_e                 op,
        input logic [2*WIDTH-1:0]  x,
        input logic [2*WIDTH-1:0]  y
    );
        logic [PW-1:0] xe;
        logic [PW-1:0] ye;
        xe = {x[2*WIDTH-1], x};
        ye = {y[2*WIDTH-1], y};
        return (op == SUB) ? (xe - ye) : (xe + ye);
    endfunction

    assign w_rr = $signed(i_a_re) * $signed(i_b_re);
    assign w_ii = $signed(i_a_im) * $signed(i_b_im);
    assign w_ir = $signed(i_a_im) * $signed(i_b_re);
    assign w_ri = $signed(i_a_re) * $signed(i_b_im);

    assign o_p_re = addsub(SUB, w_rr, w_ii);
    assign o_p_im = addsub(SUM, w_ir, w_ri);

endmodule
`default_nettype wire

// File: rtl/complex_dot_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : complex_dot_ctrl
// Description : Sequences a shared complex multiplier into a dot-product accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module complex_dot_ctrl
    import cdot_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int ACC_W   = acc_width(WIDTH, MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   aReal,
    input  logic [WIDTH-1:0]   aImag,
    input  logic [WIDTH-1:0]   bReal,
    input  logic [WIDTH-1:0]   bImag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   outReal,
    output logic [ACC_W-1:0]   outImag,
    output logic               busy
);

    localparam logic [LEN_W-1:0] c_one     = LEN_W'(1);
    localparam logic [LEN_W-1:0] c_zero    = '0;
    localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_LEN);

    state_e             r_state;
    state_e             w_next;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_cnt;
    logic [LEN_W-1:0]   w_len_eff;
    logic [ACC_W-1:0]   r_out_re;
    logic [ACC_W-1:0]   r_out_im;
    logic               w_clr;
    logic               w_ready;
    logic               w_hs;
    logic               w_pv;
    logic               w_load_out;
    logic [2*WIDTH:0]   w_p_re;
    logic [2*WIDTH:0]   w_p_im;
    logic [ACC_W-1:0]   w_acc_re;
    logic [ACC_W-1:0]   w_acc_im;

    assign w_len_eff = ((cfg_len == c_zero) || (cfg_len > c_max_len)) ? c_max_len : cfg_len;
    assign w_hs      = in_valid & w_ready;

    always_comb begin
        w_next     = r_state;
        w_ready    = 1'b0;
        w_clr      = 1'b0;
        w_load_out = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_clr  = 1'b1;
                    w_next = RUN;
                end
            end
            RUN: begin
                w_ready = 1'b1;
                if (in_valid && (r_cnt == r_len - c_one)) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                // Wait for the last product to leave the pipe before capturing the sum.
                if (!w_pv) begin
                    w_load_out = 1'b1;
                    w_next     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (start) begin
                        w_clr  = 1'b1;
                        w_next = RUN;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_len    <= '0;
            r_cnt    <= '0;
            r_out_re <= '0;
            r_out_im <= '0;
        end else begin
            r_state <= w_next;
            if (w_clr) begin
                r_len <= w_len_eff;
                r_cnt <= '0;
            end else if (w_hs) begin
                r_cnt <= r_cnt + c_one;
            end
            if (w_load_out) begin
                r_out_re <= w_acc_re;
                r_out_im <= w_acc_im;
            end
        end
    end

    complexMul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .i_a_re (aReal),
        .i_a_im (aImag),
        .i_b_re (bReal),
        .i_b_im (bImag),
        .o_p_re (w_p_re),
        .o_p_im (w_p_im)
    );

    cdot_accum #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W)
    ) u_accum (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_clr),
        .i_load   (w_hs),
        .i_p_re   (w_p_re),
        .i_p_im   (w_p_im),
        .o_acc_re (w_acc_re),
        .o_acc_im (w_acc_im),
        .o_pv     (w_pv)
    );

    assign in_ready  = w_ready;
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign outReal   = r_out_re;
    assign outImag   = r_out_im;

endmodule
`default_nettype wire

// File: tb/tb_complex_dot_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_complex_dot_ctrl
// Description : Randomized self-checking bench for complex_dot_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_complex_dot_ctrl;

    localparam int WIDTH   = 8;
    localparam int MAX_LEN = 16;
    localparam int LEN_W   = 5;
    localparam int ACC_W   = 21;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [LEN_W-1:0]   cfg_len;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   aReal, aImag, bReal, bImag;
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   outReal, outImag;
    logic               busy;

    int n_checks = 0;
    int n_fail   = 0;

    int     va_re[MAX_LEN], va_im[MAX_LEN], vb_re[MAX_LEN], vb_im[MAX_LEN];
    int     gaps[MAX_LEN];
    longint exp_re, exp_im;
    logic [ACC_W-1:0] e_re, e_im;

    complex_dot_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_len   (cfg_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aReal     (aReal),
        .aImag     (aImag),
        .bReal     (bReal),
        .bImag     (bImag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .outReal   (outReal),
        .outImag   (outImag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer complex dot product over the first n pairs.
    task automatic model(input int n);
        exp_re = 0;
        exp_im = 0;
        for (int k = 0; k < n; k++) begin
            exp_re += longint'(va_re[k] * vb_re[k] - va_im[k] * vb_im[k]);
            exp_im += longint'(va_im[k] * vb_re[k] + va_re[k] * vb_im[k]);
        end
        e_re = exp_re[ACC_W-1:0];
        e_im = exp_im[ACC_W-1:0];
    endtask

    task automatic fill_random(input int n, input int max_gap);
        for (int k = 0; k < n; k++) begin
            va_re[k] = int'($urandom_range(0, 255)) - 128;
            va_im[k] = int'($urandom_range(0, 255)) - 128;
            vb_re[k] = int'($urandom_range(0, 255)) - 128;
            vb_im[k] = int'($urandom_range(0, 255)) - 128;
            gaps[k]  = int'($urandom_range(0, max_gap));
        end
    endtask

    task automatic begin_op(input int cfg);
        logic [31:0] c;
        c       = cfg;
        start   = 1'b1;
        cfg_len = c[LEN_W-1:0];
        tick();
        start   = 1'b0;
    endtask

    // Feeds n pairs (honouring gaps[]), then counts edges from the last handshake to out_valid.
    task automatic feed(input int n, input bit hold_start, output bit tmo,
                        output int lat, output bit rdy_after);
        int waits;
        tmo = 1'b0;
        rdy_after = 1'b0;
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b0;
            repeat (gaps[k]) tick();
            aReal = va_re[k][WIDTH-1:0];
            aImag = va_im[k][WIDTH-1:0];
            bReal = vb_re[k][WIDTH-1:0];
            bImag = vb_im[k][WIDTH-1:0];
            in_valid = 1'b1;
            if (hold_start) begin
                start   = 1'b1;
                cfg_len = 5'd3;
            end
            waits = 0;
            while (!in_ready && waits < 50) begin
                tick();
                waits++;
            end
            if (waits >= 50) begin
                tmo = 1'b1;
                in_valid = 1'b0;
                start = 1'b0;
                lat = -1;
                return;
            end
            tick();
        end
        in_valid  = 1'b0;
        rdy_after = in_ready;
        lat = 0;
        while (!out_valid && lat < 30) begin
            tick();
            lat++;
        end
        start = 1'b0;
        if (!out_valid) tmo = 1'b1;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_checks++; if (outReal !== '0 || outImag !== '0) begin n_fail++; $display("FAIL reset_out got (%0d,%0d) exp (0,0)", $signed(outReal), $signed(outImag)); end
    endtask

    task automatic test_single();
        bit tmo, rdy; int lat;
        va_re[0] = 3; va_im[0] = 2; vb_re[0] = 1; vb_im[0] = -4; gaps[0] = 0;
        begin_op(1);
        n_checks++; if (busy !== 1'b1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL single_run busy=%b in_ready=%b exp 1,1", busy, in_ready); end
        feed(1, 1'b0, tmo, lat, rdy);
        n_checks++; if (tmo || lat != 2) begin n_fail++; $display("FAIL single_latency got %0d exp 2 (timeout=%0d)", lat, tmo); end
        n_checks++; if ($signed(outReal) != 11 || $signed(outImag) != -10) begin n_fail++; $display("FAIL single_result got (%0d,%0d) exp (11,-10)", $signed(outReal), $signed(outImag)); end
        consume();
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_consume out_valid=%b busy=%b exp 0,0", out_valid, busy); end
    endtask

    task automatic test_full4();
        bit tmo, rdy; int lat;
        for (int k = 0; k < 4; k++) begin
            va_re[k] = 1; va_im[k] = 1; vb_re[k] = 1; vb_im[k] = 1; gaps[k] = 0;
        end
        begin_op(4);
        feed(4, 1'b0, tmo, lat, rdy);
        n_checks++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL full4_drain_ready got %b exp 0", rdy); end
        n_checks++; if (tmo || lat != 2) begin n_fail++; $display("FAIL full4_latency got %0d exp 2 (timeout=%0d)", lat, tmo); end
        n_checks++; if ($signed(outReal) != 0 || $signed(outImag) != 8) begin n_fail++; $display("FAIL full4_result got (%0d,%0d) exp (0,8)", $signed(outReal), $signed(outImag)); end
        consume();
    endtask

    task automatic test_extreme();
        bit tmo, rdy; int lat;
        for (int k = 0; k < MAX_LEN; k++) begin
            va_re[k] = -128; va_im[k] = -128; vb_re[k] = -128; vb_im[k] = -128; gaps[k] = 0;
        end
        begin_op(16);
        feed(16, 1'b0, tmo, lat, rdy);
        n_checks++; if (tmo || $signed(outReal) != 0 || $signed(outImag) != 524288) begin n_fail++; $display("FAIL extreme_result got (%0d,%0d) exp (0,524288) timeout=%0d", $signed(outReal), $signed(outImag), tmo); end
        consume();
    endtask

    task automatic test_stall();
        bit tmo, rdy; int lat;
        va_re[0] = 1; va_im[0] = 0; vb_re[0] = 2; vb_im[0] = 0;  gaps[0] = 0;
        va_re[1] = 0; va_im[1] = 1; vb_re[1] = 0; vb_im[1] = 1;  gaps[1] = 2;
        va_re[2] = 5; va_im[2] = 5; vb_re[2] = 1; vb_im[2] = -1; gaps[2] = 1;
        begin_op(3);
        feed(3, 1'b0, tmo, lat, rdy);
        n_checks++; if (tmo || $signed(outReal) != 11 || $signed(outImag) != 0) begin n_fail++; $display("FAIL stall_result got (%0d,%0d) exp (11,0) timeout=%0d", $signed(outReal), $signed(outImag), tmo); end
        consume();
    endtask

    task automatic test_hold_restart();
        bit tmo, rdy; int lat;
        logic [ACC_W-1:0] h_re, h_im;
        fill_random(5, 1);
        model(5);
        begin_op(5);
        feed(5, 1'b0, tmo, lat, rdy);
        n_checks++; if (tmo || outReal !== e_re || outImag !== e_im) begin n_fail++; $display("FAIL hold_first got (%0d,%0d) exp (%0d,%0d)", $signed(outReal), $signed(outImag), exp_re, exp_im); end
        h_re = outReal; h_im = outImag;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++; if (out_valid !== 1'b1 || outReal !== h_re || outImag !== h_im) begin n_fail++; $display("FAIL hold_stable cycle %0d valid=%b got (%0d,%0d) exp (%0d,%0d)", c, out_valid, $signed(outReal), $signed(outImag), $signed(h_re), $signed(h_im)); end
        end
        fill_random(2, 1);
        gaps[0] = 0;
        model(2);
        out_ready = 1'b1; start = 1'b1; cfg_len = 5'd2;
        tick();
        out_ready = 1'b0; start = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL restart_state valid=%b busy=%b ready=%b exp 0,1,1", out_valid, busy, in_ready); end
        feed(2, 1'b0, tmo, lat, rdy);
        n_checks++; if (tmo || outReal !== e_re || outImag !== e_im) begin n_fail++; $display("FAIL restart_result got (%0d,%0d) exp (%0d,%0d)", $signed(outReal), $signed(outImag), exp_re, exp_im); end
        consume();
    endtask

    task automatic test_reset_mid();
        bit tmo, rdy; int lat;
        fill_random(4, 0);
        begin_op(4);
        for (int k = 0; k < 2; k++) begin
            aReal = va_re[k][WIDTH-1:0]; aImag = va_im[k][WIDTH-1:0];
            bReal = vb_re[k][WIDTH-1:0]; bImag = vb_im[k][WIDTH-1:0];
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_ctrl busy=%b ready=%b valid=%b exp 0,0,0", busy, in_ready, out_valid); end
        n_checks++; if (outReal !== '0 || outImag !== '0) begin n_fail++; $display("FAIL midreset_out got (%0d,%0d) exp (0,0)", $signed(outReal), $signed(outImag)); end
        va_re[0] = 2; va_im[0] = 0; vb_re[0] = 3; vb_im[0] = 0; gaps[0] = 0;
        begin_op(1);
        feed(1, 1'b0, tmo, lat, rdy);
        n_checks++; if (tmo || $signed(outReal) != 6 || $signed(outImag) != 0) begin n_fail++; $display("FAIL midreset_fresh got (%0d,%0d) exp (6,0)", $signed(outReal), $signed(outImag)); end
        consume();
    endtask

    task automatic test_cfg_zero();
        bit tmo, rdy; int lat;
        fill_random(MAX_LEN, 1);
        model(MAX_LEN);
        begin_op(0);
        // start held high throughout with a different length: must be ignored while running
        feed(MAX_LEN, 1'b1, tmo, lat, rdy);
        n_checks++; if (tmo || lat != 2) begin n_fail++; $display("FAIL cfg0_latency got %0d exp 2 (timeout=%0d)", lat, tmo); end
        n_checks++; if (outReal !== e_re || outImag !== e_im) begin n_fail++; $display("FAIL cfg0_result got (%0d,%0d) exp (%0d,%0d)", $signed(outReal), $signed(outImag), exp_re, exp_im); end
        consume();
    endtask

    task automatic test_random();
        bit tmo, rdy; int lat; int n;
        for (int it = 0; it < 8; it++) begin
            n = int'($urandom_range(1, MAX_LEN));
            fill_random(n, 2);
            model(n);
            begin_op(n);
            feed(n, 1'b0, tmo, lat, rdy);
            n_checks++; if (tmo || lat != 2 || outReal !== e_re || outImag !== e_im) begin n_fail++; $display("FAIL random_%0d n=%0d lat=%0d got (%0d,%0d) exp (%0d,%0d)", it, n, lat, $signed(outReal), $signed(outImag), exp_re, exp_im); end
            repeat ($urandom_range(0, 3)) tick();
            consume();
            n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL random_consume_%0d valid=%b busy=%b exp 0,0", it, out_valid, busy); end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg_len = '0; in_valid = 1'b0; out_ready = 1'b0;
        aReal = '0; aImag = '0; bReal = '0; bImag = '0;
        test_reset();
        test_single();
        test_full4();
        test_extreme();
        test_stall();
        test_hold_restart();
        test_reset_mid();
        test_cfg_zero();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
